// File: rtl/branch_predictor.sv
// Bimodal branch predictor: direct-mapped table of 2-bit saturating counters indexed by PC.
// Zero-latency lookup for fetch, one-cycle training from EX, sequential table init after reset.

module bp_counter #(
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic       clk,
    input  logic       init_we,
    input  logic       upd_we,
    input  logic       taken,
    output logic [1:0] cnt
);
    // Contents are meaningless until the init sweep has written this entry, so no reset here.
    always_ff @(posedge clk) begin
        if (init_we)
            cnt <= CNT_INIT;
        else if (upd_we) begin
            if (taken && cnt != 2'b11)
                cnt <= cnt + 2'd1;
            else if (!taken && cnt != 2'b00)
                cnt <= cnt - 2'd1;
        end
    end
endmodule

module branch_predictor #(
    parameter int          IDX_BITS = 4,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic        ex_pred_taken,
    output logic        mispredict,
    output logic        init_done
);
    localparam int ENTRIES = 2 ** IDX_BITS;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                      state;
    logic [IDX_BITS-1:0]         init_ptr;
    logic [ENTRIES-1:0][1:0]     tbl;
    logic [ENTRIES-1:0]          init_we;
    logic [ENTRIES-1:0]          upd_we;
    logic [IDX_BITS-1:0]         if_idx;
    logic [IDX_BITS-1:0]         ex_idx;
    logic                        unused_pc_bits;

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign unused_pc_bits = ^{if_pc[31:IDX_BITS+2], if_pc[1:0], ex_pc[31:IDX_BITS+2], ex_pc[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_INIT;
            init_ptr  <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    init_ptr <= init_ptr + 1'b1;
                    if (init_ptr == {IDX_BITS{1'b1}}) begin
                        state     <= S_RUN;
                        init_done <= 1'b1;
                    end
                end
                S_RUN: state <= S_RUN;
                default: state <= S_INIT;
            endcase
        end
    end

    // Training is ignored during the init sweep; only RUN writes back resolved outcomes.
    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        assign init_we[g] = !rst && state == S_INIT && init_ptr == IDX_BITS'(g);
        assign upd_we[g]  = state == S_RUN && ex_valid && ex_idx == IDX_BITS'(g);

        bp_counter #(.CNT_INIT(CNT_INIT)) u_cnt (
            .clk     (clk),
            .init_we (init_we[g]),
            .upd_we  (upd_we[g]),
            .taken   (ex_taken),
            .cnt     (tbl[g])
        );
    end

    // Lookup reads the registered counter, so a same-cycle update is seen one cycle later.
    assign pred_taken = init_done & tbl[if_idx][1];
    assign mispredict = !rst & ex_valid & (ex_taken ^ ex_pred_taken);
endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed checks of branch_predictor against an array-based counter model.

module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = '0;
    logic        pred_taken;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_taken = 1'b0;
    logic        ex_pred_taken = 1'b0;
    logic        mispredict;
    logic        init_done;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: counter values as plain integers, init progress as a cycle count.
    int tbl [16];
    int init_cycles = 0;
    bit model_done = 0;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_BITS(4), .CNT_INIT(2'b01)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_taken      (ex_taken),
        .ex_pred_taken (ex_pred_taken),
        .mispredict    (mispredict),
        .init_done     (init_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return (pc / 4) % 16;
    endfunction

    function automatic void model_reset();
        init_cycles = 0;
        model_done  = 0;
    endfunction

    // One cycle: apply inputs, check outputs mid-cycle, then advance the model on the edge.
    task automatic drive(input logic [31:0] ipc, input logic v, input logic [31:0] epc,
                         input logic t, input logic p);
        if_pc = ipc; ex_valid = v; ex_pc = epc; ex_taken = t; ex_pred_taken = p;
        @(negedge clk);
        chk("init_done", init_done, model_done);
        chk("pred", pred_taken, model_done && tbl[idx_of(ipc)] >= 2);
        chk("mispredict", mispredict, v && (t != p));
        @(posedge clk);
        if (!model_done) begin
            init_cycles++;
            if (init_cycles == 16) begin
                model_done = 1;
                foreach (tbl[i]) tbl[i] = 1;
            end
        end else if (v) begin
            if (t) tbl[idx_of(epc)] = (tbl[idx_of(epc)] == 3) ? 3 : tbl[idx_of(epc)] + 1;
            else   tbl[idx_of(epc)] = (tbl[idx_of(epc)] == 0) ? 0 : tbl[idx_of(epc)] - 1;
        end
        #1;
    endtask

    task automatic train(input logic [31:0] pc, input logic t, input int n);
        for (int i = 0; i < n; i++) drive(32'h0, 1'b1, pc, t, 1'b0);
    endtask

    task automatic expect_pred(input string tag, input logic [31:0] pc, input logic exp);
        if_pc = pc; ex_valid = 1'b0;
        #2;
        chk(tag, pred_taken, exp);
        drive(pc, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic run_init(input bit rnd);
        for (int i = 0; i < 16; i++)
            drive($urandom, rnd ? 1'($urandom) : 1'b0, $urandom, 1'($urandom), 1'($urandom));
    endtask

    initial begin
        // Reset and init sweep, with dropped training traffic during INIT
        #3;
        chk("rst_pred", pred_taken, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_mispredict", mispredict, 1'b0);
        #14 rst = 1'b0;
        model_reset();
        run_init(1);
        chk("init_done_after16", init_done, 1'b1);
        for (int i = 0; i < 16; i++) expect_pred("post_init", 32'(i * 4), 1'b0);

        // Training and hysteresis on 0x0C
        train(32'h0C, 1'b1, 1);
        expect_pred("hyst_10", 32'h0C, 1'b1);
        train(32'h0C, 1'b1, 1);
        train(32'h0C, 1'b0, 1);
        expect_pred("hyst_11_to_10", 32'h0C, 1'b1);
        train(32'h0C, 1'b0, 1);
        expect_pred("hyst_01", 32'h0C, 1'b0);

        // Saturation on 0x20
        train(32'h20, 1'b1, 5);
        expect_pred("sat_hi", 32'h20, 1'b1);
        train(32'h20, 1'b0, 1);
        expect_pred("sat_hi_one_down", 32'h20, 1'b1);
        train(32'h20, 1'b0, 4);
        expect_pred("sat_lo", 32'h20, 1'b0);
        train(32'h20, 1'b1, 1);
        expect_pred("sat_lo_no_wrap", 32'h20, 1'b0);

        // Aliasing: 0x4C shares index 3 with 0x0C, 0x10 does not
        train(32'h0C, 1'b1, 2);
        expect_pred("alias_4c", 32'h4C, 1'b1);
        expect_pred("alias_10", 32'h10, 1'b0);

        // Mispredict flag and same-index read/write collision
        if_pc = 32'h0; ex_valid = 1'b1; ex_pc = 32'h30; ex_taken = 1'b1; ex_pred_taken = 1'b0;
        #1 chk("misp_set", mispredict, 1'b1);
        ex_pred_taken = 1'b1;
        #1 chk("misp_match", mispredict, 1'b0);
        ex_valid = 1'b0; ex_pred_taken = 1'b0;
        #1 chk("misp_invalid", mispredict, 1'b0);
        drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        if_pc = 32'h08; ex_valid = 1'b1; ex_pc = 32'h08; ex_taken = 1'b1; ex_pred_taken = 1'b0;
        #2 chk("collide_old", pred_taken, 1'b0);
        drive(32'h08, 1'b1, 32'h08, 1'b1, 1'b0);
        expect_pred("collide_new", 32'h08, 1'b1);

        // Randomized traffic over a small PC range to force aliasing and saturation
        for (int i = 0; i < 400; i++)
            drive({$urandom_range(0, 63), 2'($urandom)}, 1'($urandom),
                  {$urandom_range(0, 63), 2'($urandom)}, 1'($urandom), 1'($urandom));

        // Asynchronous reset mid-run
        train(32'h0C, 1'b1, 4);
        expect_pred("pre_rst_sat", 32'h0C, 1'b1);
        if_pc = 32'h0C; ex_valid = 1'b1; ex_taken = 1'b1; ex_pred_taken = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("midrst_init_done", init_done, 1'b0);
        chk("midrst_pred", pred_taken, 1'b0);
        chk("midrst_mispredict", mispredict, 1'b0);
        #1 rst = 1'b0;
        model_reset();
        run_init(1);
        expect_pred("post_rst_0c", 32'h0C, 1'b0);
        for (int i = 0; i < 100; i++)
            drive($urandom, 1'($urandom), $urandom, 1'($urandom), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
